// File: rtl/pll_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pll_cfg_pkg
// Shared types and constants for the PLL reconfiguration sequencer.
//   state_t    : sequencer states (S_WR_PS only exists with PLL_CFG_DPS_EN)
//   REG_*      : altera_pll_reconfig register addresses
//   C_W        : width of one N/M/C counter word
//   next_set() : lowest set bit of a channel vector at or above a start index
// Optional feature macro: PLL_CFG_DPS_EN (dynamic phase-shift writes).
// -----------------------------------------------------------------------------
package pll_cfg_pkg;

    localparam int C_W = 18;

    localparam logic [5:0] REG_MODE  = 6'h00;
    localparam logic [5:0] REG_START = 6'h02;
    localparam logic [5:0] REG_N     = 6'h03;
    localparam logic [5:0] REG_M     = 6'h04;
    localparam logic [5:0] REG_C     = 6'h05;
    localparam logic [5:0] REG_DPS   = 6'h06;
    localparam logic [5:0] REG_K     = 6'h07;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_K,
        S_WR_C,
        S_START,
        S_WAIT_LOCK
`ifdef PLL_CFG_DPS_EN
        , S_WR_PS
`endif
    } state_t;

    // Returns {found, index}. Vector is padded to the 18-channel maximum so the
    // same helper serves any NUM_CLK. Descending scan leaves the lowest hit.
    function automatic logic [5:0] next_set(input logic [17:0] v, input logic [4:0] from);
        logic [5:0] r;
        r = '0;
        for (int i = 17; i >= 0; i--) begin
            if (v[i] && (5'(i) >= from)) r = {1'b1, 5'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_cfg_lockmon.sv
// -----------------------------------------------------------------------------
// pll_cfg_lockmon
// Lock qualification and monitoring for the PLL reconfiguration sequencer.
//   i_clk, i_rst_n : management clock, async active-low reset
//   i_locked       : PLL lock (already synchronised)
//   i_wait         : sequencer is in WAIT_LOCK; both counters run only here
//   i_idle         : sequencer is idle; lock losses are counted only here
//   i_clr          : request accepted; clears the lock-loss count
//   o_lock_ok      : this cycle is the LOCK_FILTER-th consecutive locked cycle
//   o_timeout      : this cycle is the LOCK_TIMEOUT-th cycle in WAIT_LOCK
//   o_lost_cnt     : saturating count of locked falling edges while idle
// -----------------------------------------------------------------------------
module pll_cfg_lockmon #(
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_locked,
    input  logic       i_wait,
    input  logic       i_idle,
    input  logic       i_clr,
    output logic       o_lock_ok,
    output logic       o_timeout,
    output logic [7:0] o_lost_cnt
);

    // Counters only need to reach limit-1: the limit-th cycle is flagged combinationally.
    localparam int FW = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [FW-1:0] r_filt;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_lost;
    logic          r_lock_d;

    assign o_lock_ok  = i_wait && i_locked && (r_filt == FW'(LOCK_FILTER - 1));
    assign o_timeout  = i_wait && (r_tmo == TW'(LOCK_TIMEOUT - 1));
    assign o_lost_cnt = r_lost;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt   <= '0;
            r_tmo    <= '0;
            r_lost   <= '0;
            r_lock_d <= 1'b0;
        end else begin
            r_lock_d <= i_locked;

            if (!i_wait || !i_locked || o_lock_ok) r_filt <= '0;
            else                                   r_filt <= r_filt + FW'(1);

            // Cleared outside WAIT_LOCK, so counting effectively starts at START accept.
            if (!i_wait || o_timeout) r_tmo <= '0;
            else                      r_tmo <= r_tmo + TW'(1);

            if (i_clr)
                r_lost <= '0;
            else if (i_idle && r_lock_d && !i_locked && (r_lost != 8'hFF))
                r_lost <= r_lost + 8'd1;
        end
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// -----------------------------------------------------------------------------
// pll_cfg_seq
// Reconfiguration sequencer for a fractional PLL through the altera_pll_reconfig
// Avalon-MM management port. Latches a frequency set, writes MODE, N, M, [K],
// masked C counters and START, then waits for a filtered lock with retries.
//   mgmt_clk, mgmt_reset_n : clock, async active-low reset
//   cfg_req                : start request (IDLE only)
//   cfg_n/m/k/frac_en      : N, M, fractional K and K-write enable
//   cfg_c, cfg_c_mask      : C counter words (18 bits per channel) and write mask
//   cfg_ps_steps/ps_dir    : phase-shift steps/direction (PLL_CFG_DPS_EN only)
//   busy, done, error      : status (done one-cycle pulse, error sticky)
//   lock_lost_cnt          : saturating lock-loss count while idle
//   mgmt_*                 : Avalon-MM master (waitrequest handshake)
//   pll_locked             : synchronised PLL lock
// Optional feature macro: PLL_CFG_DPS_EN adds post-lock phase-shift writes.
// -----------------------------------------------------------------------------
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int NUM_CLK      = 3,
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int MAX_RETRY    = 2
) (
    input  logic                   mgmt_clk,
    input  logic                   mgmt_reset_n,
    input  logic                   cfg_req,
    input  logic [C_W-1:0]         cfg_n,
    input  logic [C_W-1:0]         cfg_m,
    input  logic [31:0]            cfg_k,
    input  logic                   cfg_frac_en,
    input  logic [NUM_CLK*C_W-1:0] cfg_c,
    input  logic [NUM_CLK-1:0]     cfg_c_mask,
`ifdef PLL_CFG_DPS_EN
    input  logic [NUM_CLK*16-1:0]  cfg_ps_steps,
    input  logic [NUM_CLK-1:0]     cfg_ps_dir,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             lock_lost_cnt,
    output logic [5:0]             mgmt_address,
    output logic                   mgmt_write,
    output logic [31:0]            mgmt_writedata,
    input  logic                   mgmt_waitrequest,
    input  logic                   pll_locked
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t                        r_state;
    logic                          r_write;
    logic [5:0]                    r_addr;
    logic [31:0]                   r_data;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_err;
    logic [RW-1:0]                 r_retry;
    logic [4:0]                    r_idx;
    logic [C_W-1:0]                r_n;
    logic [C_W-1:0]                r_m;
    logic [31:0]                   r_k;
    logic                          r_frac_en;
    logic [NUM_CLK-1:0][C_W-1:0]   r_c;
    logic [NUM_CLK-1:0]            r_mask;

    state_t                        w_next;
    logic [5:0]                    w_addr;
    logic [31:0]                   w_data;
    logic [C_W-1:0]                w_c_word;
    logic [17:0]                   w_srch_vec;
    logic [4:0]                    w_srch_from;
    logic [5:0]                    w_hit;
    logic                          w_lock_ok;
    logic                          w_timeout;

`ifdef PLL_CFG_DPS_EN
    logic [NUM_CLK-1:0][15:0]      r_ps_steps;
    logic [NUM_CLK-1:0]            r_ps_dir;
    logic [NUM_CLK-1:0]            w_ps_vec;
    logic [15:0]                   w_ps_steps;
    logic                          w_ps_dir;

    always_comb begin
        w_ps_steps = '0;
        w_ps_dir   = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            w_ps_vec[i] = r_mask[i] && (r_ps_steps[i] != 16'd0);
            if (r_idx == 5'(i)) begin
                w_ps_steps = r_ps_steps[i];
                w_ps_dir   = r_ps_dir[i];
            end
        end
    end
`endif

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_err;
    assign mgmt_address   = r_addr;
    assign mgmt_write     = r_write;
    assign mgmt_writedata = r_data;

    always_comb begin
        w_c_word = '0;
        for (int i = 0; i < NUM_CLK; i++)
            if (r_idx == 5'(i)) w_c_word = r_c[i];
    end

    // One shared search: from 0 when entering a channel loop, from idx+1 inside it.
    always_comb begin
        w_srch_vec  = 18'(r_mask);
        w_srch_from = '0;
        if (r_state == S_WR_C) w_srch_from = r_idx + 5'd1;
`ifdef PLL_CFG_DPS_EN
        if (r_state == S_WAIT_LOCK) w_srch_vec = 18'(w_ps_vec);
        if (r_state == S_WR_PS) begin
            w_srch_vec  = 18'(w_ps_vec);
            w_srch_from = r_idx + 5'd1;
        end
`endif
    end

    assign w_hit = next_set(w_srch_vec, w_srch_from);

    // Successor of a write state, taken on that write's accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_MODE:         w_next = S_WR_N;
            S_WR_N:         w_next = S_WR_M;
            S_WR_M:         w_next = r_frac_en ? S_WR_K : (w_hit[5] ? S_WR_C : S_START);
            S_WR_K, S_WR_C: w_next = w_hit[5] ? S_WR_C : S_START;
            S_START:        w_next = S_WAIT_LOCK;
`ifdef PLL_CFG_DPS_EN
            S_WR_PS:        w_next = w_hit[5] ? S_WR_PS : S_IDLE;
`endif
            default:        w_next = r_state;
        endcase
    end

    always_comb begin
        w_addr = REG_MODE;
        w_data = '0;
        case (r_state)
            S_WR_N:  begin w_addr = REG_N;     w_data = {14'b0, r_n}; end
            S_WR_M:  begin w_addr = REG_M;     w_data = {14'b0, r_m}; end
            S_WR_K:  begin w_addr = REG_K;     w_data = r_k; end
            S_WR_C:  begin w_addr = REG_C;     w_data = {9'b0, r_idx, w_c_word}; end
            S_START: begin w_addr = REG_START; w_data = '0; end
`ifdef PLL_CFG_DPS_EN
            S_WR_PS: begin w_addr = REG_DPS;   w_data = {10'b0, w_ps_dir, r_idx, w_ps_steps}; end
`endif
            default: begin w_addr = REG_MODE;  w_data = '0; end
        endcase
    end

    pll_cfg_lockmon #(
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lockmon (
        .i_clk      (mgmt_clk),
        .i_rst_n    (mgmt_reset_n),
        .i_locked   (pll_locked),
        .i_wait     (r_state == S_WAIT_LOCK),
        .i_idle     (r_state == S_IDLE),
        .i_clr      ((r_state == S_IDLE) && cfg_req),
        .o_lock_ok  (w_lock_ok),
        .o_timeout  (w_timeout),
        .o_lost_cnt (lock_lost_cnt)
    );

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_retry   <= '0;
            r_idx     <= '0;
            r_n       <= '0;
            r_m       <= '0;
            r_k       <= '0;
            r_frac_en <= 1'b0;
            r_c       <= '0;
            r_mask    <= '0;
`ifdef PLL_CFG_DPS_EN
            r_ps_steps <= '0;
            r_ps_dir   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_write <= 1'b0;
                    if (cfg_req) begin
                        r_n       <= cfg_n;
                        r_m       <= cfg_m;
                        r_k       <= cfg_k;
                        r_frac_en <= cfg_frac_en;
                        r_c       <= cfg_c;
                        r_mask    <= cfg_c_mask;
`ifdef PLL_CFG_DPS_EN
                        r_ps_steps <= cfg_ps_steps;
                        r_ps_dir   <= cfg_ps_dir;
`endif
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_retry   <= '0;
                        r_state   <= S_MODE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_ok) begin
`ifdef PLL_CFG_DPS_EN
                        if (w_hit[5]) begin
                            r_idx   <= w_hit[4:0];
                            r_state <= S_WR_PS;
                        end else
`endif
                        begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        if (r_retry < RW'(MAX_RETRY)) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_MODE;
                        end else begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    // Write states: strobe is raised one cycle after entry and
                    // dropped on accept, which gives the mandatory gap cycle.
                    if (!r_write) begin
                        r_write <= 1'b1;
                        r_addr  <= w_addr;
                        r_data  <= w_data;
                    end else if (!mgmt_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= w_next;
                        r_idx   <= w_hit[4:0];
                        if (w_next == S_IDLE) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_cfg_seq
// Randomised self-checking bench for pll_cfg_seq (NUM_CLK=3, LOCK_FILTER=16,
// LOCK_TIMEOUT=100, MAX_RETRY=2). Expected write lists are built from the
// latched settings; lock qualification is modelled as a run length of locked
// cycles counted from the START accept.
// -----------------------------------------------------------------------------
module tb_pll_cfg_seq;
    import pll_cfg_pkg::*;

    localparam int NC = 3;
    localparam int LF = 16;
    localparam int LT = 100;
    localparam int MR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_req = 1'b0;
    logic [17:0]       cfg_n = '0;
    logic [17:0]       cfg_m = '0;
    logic [31:0]       cfg_k = '0;
    logic              cfg_frac_en = 1'b0;
    logic [NC*18-1:0]  cfg_c = '0;
    logic [NC-1:0]     cfg_c_mask = '0;
    logic              busy, done, error;
    logic [7:0]        lock_lost_cnt;
    logic [5:0]        mgmt_address;
    logic              mgmt_write;
    logic [31:0]       mgmt_writedata;
    logic              mgmt_waitrequest = 1'b0;
    logic              pll_locked = 1'b0;

    always #5 clk = ~clk;

    pll_cfg_seq #(
        .NUM_CLK(NC), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)
    ) dut (
        .mgmt_clk         (clk),
        .mgmt_reset_n     (rst_n),
        .cfg_req          (cfg_req),
        .cfg_n            (cfg_n),
        .cfg_m            (cfg_m),
        .cfg_k            (cfg_k),
        .cfg_frac_en      (cfg_frac_en),
        .cfg_c            (cfg_c),
        .cfg_c_mask       (cfg_c_mask),
`ifdef PLL_CFG_DPS_EN
        .cfg_ps_steps     ('0),
        .cfg_ps_dir       ('0),
`endif
        .busy             (busy),
        .done             (done),
        .error            (error),
        .lock_lost_cnt    (lock_lost_cnt),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [37:0] obs[$];
    logic [37:0] exp_q[$];
    bit          in_wait = 0;
    int          run = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          n_strb_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record the pre-edge bus/lock state, then sample 1ns after the edge.
    task automatic step();
        logic        acc, stall;
        logic [37:0] ad;
        acc   = mgmt_write && !mgmt_waitrequest;
        stall = mgmt_write && mgmt_waitrequest;
        ad    = {mgmt_address, mgmt_writedata};
        if (mgmt_write && mgmt_address == 6'h03) n_strb_n++;
        if (in_wait) run = pll_locked ? run + 1 : 0;
        if (acc) begin
            obs.push_back(ad);
            if (mgmt_address == 6'h02) begin
                in_wait = 1;
                run     = 0;
                n_start++;
            end
        end
        @(posedge clk);
        #1;
        if (acc)   chk("gap_after_accept", mgmt_write, 1'b0);
        if (stall) chk("hold_while_stalled", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, ad});
        if (in_wait) begin
            chk("done_timing", done, run == LF);
            if (run == LF) begin
                chk("busy_low_at_done", busy, 1'b0);
                in_wait = 0;
            end
        end
        if (done) n_done++;
    endtask

    // wmode: 0 zero-wait, 1 random stalls, 2 five-cycle stall on the N write.
    // lmode: 0 lock at once, 1 lock with one glitch at run 10, 2 never lock.
    task automatic run_cfg(input int wmode, input int lmode, input logic [NC-1:0] mask, input logic fe);
        logic [NC-1:0][17:0] cv;
        logic [17:0] n, m;
        logic [31:0] k;
        int          reps, hold_n;
        bit          fin, glitched;
        n = 18'($urandom);
        m = 18'($urandom);
        k = $urandom;
        for (int i = 0; i < NC; i++) cv[i] = 18'($urandom);
        cfg_n = n; cfg_m = m; cfg_k = k; cfg_c = cv; cfg_c_mask = mask; cfg_frac_en = fe;
        reps = (lmode == 2) ? MR + 1 : 1;
        exp_q.delete(); obs.delete();
        n_start = 0; n_done = 0; n_strb_n = 0; in_wait = 0; run = 0;
        hold_n = 0; fin = 0; glitched = 0;
        for (int r = 0; r < reps; r++) begin
            exp_q.push_back({6'h00, 32'h0});
            exp_q.push_back({6'h03, 14'h0, n});
            exp_q.push_back({6'h04, 14'h0, m});
            if (fe) exp_q.push_back({6'h07, k});
            for (int i = 0; i < NC; i++)
                if (mask[i]) exp_q.push_back({6'h05, 9'h0, 5'(i), cv[i]});
            exp_q.push_back({6'h02, 32'h0});
        end

        mgmt_waitrequest = 1'b0;
        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("error_cleared", error, 1'b0);
        chk("lost_cnt_cleared", lock_lost_cnt, 8'd0);
        // Inputs change after accept; only latched values may appear on the bus.
        cfg_n = ~n; cfg_m = ~m; cfg_k = ~k; cfg_c = ~cv; cfg_c_mask = ~mask; cfg_frac_en = ~fe;

        for (int t = 0; t < 800 && !fin; t++) begin
            case (wmode)
                0: mgmt_waitrequest = 1'b0;
                1: mgmt_waitrequest = ($urandom_range(0, 2) == 0);
                default: begin
                    if (mgmt_write && mgmt_address == 6'h03 && hold_n < 5) begin
                        mgmt_waitrequest = 1'b1;
                        hold_n++;
                    end else mgmt_waitrequest = 1'b0;
                end
            endcase
            if (!in_wait) pll_locked = 1'b0;
            else case (lmode)
                0: pll_locked = 1'b1;
                1: if (run == 10 && !glitched) begin pll_locked = 1'b0; glitched = 1; end
                   else pll_locked = 1'b1;
                default: pll_locked = 1'b0;
            endcase
            cfg_req = ($urandom_range(0, 3) == 0);  // must be ignored while busy
            step();
            if (done || error) fin = 1;
        end
        cfg_req = 1'b0;
        mgmt_waitrequest = 1'b0;
        chk("sequence_finished", fin, 1'b1);
        chk("write_count", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk("write_addr_data", (i < obs.size()) ? obs[i] : 38'h3f_ffff_ffff, exp_q[i]);
        chk("start_count", n_start, reps);
        if (wmode == 2) chk("n_strobe_cycles", n_strb_n, 6);
        if (lmode == 2) begin
            chk("error_set", error, 1'b1);
            chk("busy_low_at_error", busy, 1'b0);
            chk("no_done_on_error", n_done, 0);
            step();
            chk("error_sticky", error, 1'b1);
        end else begin
            chk("done_once", n_done, 1);
            step();
            chk("done_single_pulse", done, 1'b0);
            chk("idle_not_busy", busy, 1'b0);
        end
        in_wait = 0;
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_write", mgmt_write, 1'b0);
        chk("rst_addr", mgmt_address, 6'h0);
        chk("rst_data", mgmt_writedata, 32'h0);
        chk("rst_lost", lock_lost_cnt, 8'h0);
        rst_n = 1'b1;
        step();

        run_cfg(0, 0, 3'b111, 1'b1);
        run_cfg(0, 0, 3'b010, 1'b0);
        run_cfg(2, 0, 3'($urandom), 1'($urandom));
        run_cfg(1, 1, 3'b111, 1'b1);

        // pll_locked is high here; drop it three times while idle.
        repeat (3) begin
            pll_locked = 1'b0; step();
            pll_locked = 1'b1; step();
        end
        chk("lost_cnt_3", lock_lost_cnt, 8'd3);
        repeat (260) begin
            pll_locked = 1'b0; step();
            pll_locked = 1'b1; step();
        end
        chk("lost_cnt_saturates", lock_lost_cnt, 8'd255);

        run_cfg(1, 2, 3'($urandom), 1'($urandom));
        run_cfg(1, 0, 3'b000, 1'b1);
        repeat (4) run_cfg(1, 0, 3'($urandom), 1'($urandom));

        // Reset while a C write is on the bus.
        cfg_c_mask = 3'b111; cfg_frac_en = 1'b0;
        mgmt_waitrequest = 1'b1;
        cfg_req = 1'b1; step(); cfg_req = 1'b0;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            mgmt_waitrequest = (mgmt_write && mgmt_address == 6'h05) ? 1'b1 : 1'b0;
            if (mgmt_write && mgmt_address == 6'h05) found = 1;
            else step();
        end
        chk("reached_wr_c", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_write", mgmt_write, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        in_wait = 0;
        obs.delete();
        mgmt_waitrequest = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("post_rst_no_write", mgmt_write, 1'b0);
            chk("post_rst_idle", busy, 1'b0);
        end
        chk("post_rst_no_accepts", obs.size(), 0);
        run_cfg(1, 0, 3'b101, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
